// File: rtl/pad_bus_arbiter.sv
// pad_bus_arbiter
//   Round-robin arbiter and turnaround sequencer for a shared tristate bus
//   (several tristate drivers on one net, driven out through bidirectional
//   pads). Grants the bus to one requester at a time. Inserts TURN idle cycles
//   between owners so that no two drivers ever overlap. Forcibly releases an
//   owner after MAXHOLD cycles when another agent is waiting.
//
//   Ports:
//     CK       in   clock, rising edge
//     RN       in   asynchronous active-low reset
//     req      in   [NREQ]  level request per agent
//     grant    out  [NREQ]  one-hot or zero, current owner
//     en_n     out  [NREQ]  active-low tristate drive enables (~grant)
//     oen      out          active-low pad output enable, 0 only while owned
//     owner    out  [clog2] index of current or last owner
//     busy     out          high in OWN or TURN
//     preempt  out          one-cycle pulse on a MAXHOLD forced release
//
//   Every output is a flop, so the pad enables cannot glitch and there is no
//   combinational path from req to any output.
module pad_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int TURN    = 1,
  parameter int MAXHOLD = 16
) (
  input  logic                    CK,
  input  logic                    RN,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         en_n,
  output logic                    oen,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic                    preempt
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  state_t          state_reg;
  logic [NREQ-1:0] grant_reg;
  logic [NREQ-1:0] en_n_reg;
  logic            oen_reg;
  logic [OW-1:0]   owner_reg;
  logic            busy_reg;
  logic            preempt_reg;
  logic [7:0]      hold_cnt_reg;
  logic [2:0]      turn_cnt_reg;

  // Candidate gi-1 is the agent gi positions after the last owner, so the
  // last owner itself is always the final candidate considered.
  logic [OW-1:0]   cand_idx [NREQ];
  logic [NREQ-1:0] cand_hit;

  genvar gi;
  generate
    for (gi = 1; gi <= NREQ; gi++) begin : g_cand
      assign cand_idx[gi-1] = OW'((int'(owner_reg) + gi) % NREQ);
      assign cand_hit[gi-1] = req[cand_idx[gi-1]];
    end
  endgenerate

  logic [OW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic            any_req;
  logic            other_pending;
  logic            hold_full;
  logic            turn_done;

  // Descending scan: the lowest-numbered hit (closest after owner) is written
  // last and therefore wins.
  always_comb begin
    win_idx = owner_reg;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) win_idx = cand_idx[i];
    end
  end

  assign win_onehot    = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
  assign any_req       = |req;
  assign other_pending = |(req & ~grant_reg);
  assign hold_full     = (hold_cnt_reg == 8'(MAXHOLD));
  assign turn_done     = (turn_cnt_reg == 3'(TURN));

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      en_n_reg     <= '1;
      oen_reg      <= 1'b1;
      owner_reg    <= OW'(NREQ - 1);
      busy_reg     <= 1'b0;
      preempt_reg  <= 1'b0;
      hold_cnt_reg <= '0;
      turn_cnt_reg <= '0;
    end else begin
      preempt_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            state_reg    <= ST_OWN;
            grant_reg    <= win_onehot;
            en_n_reg     <= ~win_onehot;
            oen_reg      <= 1'b0;
            owner_reg    <= win_idx;
            busy_reg     <= 1'b1;
            hold_cnt_reg <= 8'd1;
          end
        end

        ST_OWN: begin
          if (!req[owner_reg] || (other_pending && hold_full)) begin
            // Voluntary release, or forced release when someone is waiting.
            state_reg    <= ST_TURN;
            grant_reg    <= '0;
            en_n_reg     <= '1;
            oen_reg      <= 1'b1;
            busy_reg     <= 1'b1;
            hold_cnt_reg <= '0;
            turn_cnt_reg <= 3'd1;
            preempt_reg  <= req[owner_reg];
          end else if (!hold_full) begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
          end
        end

        ST_TURN: begin
          if (turn_done) begin
            turn_cnt_reg <= '0;
            if (any_req) begin
              state_reg    <= ST_OWN;
              grant_reg    <= win_onehot;
              en_n_reg     <= ~win_onehot;
              oen_reg      <= 1'b0;
              owner_reg    <= win_idx;
              busy_reg     <= 1'b1;
              hold_cnt_reg <= 8'd1;
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            turn_cnt_reg <= turn_cnt_reg + 3'd1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          grant_reg <= '0;
          en_n_reg  <= '1;
          oen_reg   <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign grant   = grant_reg;
  assign en_n    = en_n_reg;
  assign oen     = oen_reg;
  assign owner   = owner_reg;
  assign busy    = busy_reg;
  assign preempt = preempt_reg;

endmodule

// File: tb/tb_pad_bus_arbiter.sv
// Testbench for pad_bus_arbiter. dut_a: NREQ=4, TURN=1, MAXHOLD=4.
// dut_b: NREQ=4, TURN=3, MAXHOLD=16. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_pad_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn_a, rn_b;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, en_n_a, grant_b, en_n_b;
  logic       oen_a, busy_a, preempt_a, oen_b, busy_b, preempt_b;
  logic [1:0] owner_a, owner_b;

  pad_bus_arbiter #(.NREQ(4), .TURN(1), .MAXHOLD(4)) dut_a (
    .CK(clk), .RN(rn_a), .req(req_a), .grant(grant_a), .en_n(en_n_a),
    .oen(oen_a), .owner(owner_a), .busy(busy_a), .preempt(preempt_a)
  );

  pad_bus_arbiter #(.NREQ(4), .TURN(3), .MAXHOLD(16)) dut_b (
    .CK(clk), .RN(rn_b), .req(req_b), .grant(grant_b), .en_n(en_n_b),
    .oen(oen_b), .owner(owner_b), .busy(busy_b), .preempt(preempt_b)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic       preempt;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reset dut_a with a given request pattern; RN releases on a falling edge.
  task automatic reset_a(input logic [3:0] r);
    rn_a  = 1'b0;
    req_a = r;
    @(negedge clk);
    @(negedge clk);
    rn_a = 1'b1;
  endtask

  task automatic test_reset;
    exp_t e;
    rn_a  = 1'b0;
    req_a = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    checks++; if (en_n_a !== 4'b1111) begin failures++; $display("FAIL reset_en_n got=%b exp=1111", en_n_a); end
    checks++; if (oen_a !== 1'b1) begin failures++; $display("FAIL reset_oen got=%b exp=1", oen_a); end
    checks++; if (grant_a !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant_a); end
    checks++; if (owner_a !== 2'd3) begin failures++; $display("FAIL reset_owner got=%0d exp=3", owner_a); end
    checks++; if (busy_a !== 1'b0 || preempt_a !== 1'b0) begin failures++; $display("FAIL reset_busy_preempt got=%b%b exp=00", busy_a, preempt_a); end
    rn_a = 1'b1;
    exp_q.push_back('{grant: 4'b0001, preempt: 1'b0, busy: 1'b1});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (grant_a !== e.grant) begin failures++; $display("FAIL first_grant got=%b exp=%b", grant_a, e.grant); end
    checks++; if (en_n_a !== 4'b1110) begin failures++; $display("FAIL first_en_n got=%b exp=1110", en_n_a); end
    checks++; if (oen_a !== 1'b0) begin failures++; $display("FAIL first_oen got=%b exp=0", oen_a); end
    checks++; if (owner_a !== 2'd0) begin failures++; $display("FAIL first_owner got=%0d exp=0", owner_a); end
    $display("test_reset done: grant after release=%b", grant_a);
  endtask

  task automatic test_round_robin;
    logic [3:0] seq [17];
    exp_t e;
    seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
            4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
            4'b0001};
    reset_a(4'b1111);
    for (int n = 0; n < 17; n++) begin
      exp_q.push_back('{grant: seq[n], preempt: 1'b0, busy: 1'b1});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (grant_a !== e.grant) begin failures++; $display("FAIL rr_grant n=%0d got=%b exp=%b", n, grant_a, e.grant); end
      checks++; if (en_n_a !== ~e.grant || oen_a !== (e.grant == 4'b0000)) begin failures++; $display("FAIL rr_enables n=%0d en_n=%b oen=%b exp_en_n=%b", n, en_n_a, oen_a, ~e.grant); end
      checks++; if (busy_a !== e.busy || preempt_a !== e.preempt) begin failures++; $display("FAIL rr_busy_preempt n=%0d got=%b%b exp=%b%b", n, busy_a, preempt_a, e.busy, e.preempt); end
      // Each owner drops its request after its third granted cycle.
      req_a = 4'b1111;
      if (n % 4 == 2) req_a[n / 4] = 1'b0;
    end
    $display("test_round_robin done: final grant=%b", grant_a);
  endtask

  task automatic test_preempt;
    logic [3:0] gseq [11];
    logic       pseq [11];
    exp_t e;
    gseq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
             4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0100};
    pseq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    reset_a(4'b0100);
    for (int n = 0; n < 11; n++) begin
      exp_q.push_back('{grant: gseq[n], preempt: pseq[n], busy: 1'b1});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (grant_a !== e.grant) begin failures++; $display("FAIL pre_grant n=%0d got=%b exp=%b", n, grant_a, e.grant); end
      checks++; if (preempt_a !== e.preempt) begin failures++; $display("FAIL pre_pulse n=%0d got=%b exp=%b", n, preempt_a, e.preempt); end
      checks++; if (oen_a !== (e.grant == 4'b0000) || busy_a !== e.busy) begin failures++; $display("FAIL pre_oen_busy n=%0d oen=%b busy=%b", n, oen_a, busy_a); end
      req_a = 4'b0110;
    end
    $display("test_preempt done: final grant=%b", grant_a);
  endtask

  task automatic test_solo_owner;
    exp_t e;
    reset_a(4'b1000);
    for (int n = 0; n < 100; n++) begin
      exp_q.push_back('{grant: 4'b1000, preempt: 1'b0, busy: 1'b1});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (grant_a !== e.grant || preempt_a !== e.preempt) begin failures++; $display("FAIL solo n=%0d grant=%b preempt=%b exp=%b/%b", n, grant_a, preempt_a, e.grant, e.preempt); end
    end
    req_a = 4'b0000;
    $display("test_solo_owner done: grant=%b", grant_a);
  endtask

  task automatic test_turnaround;
    logic [3:0] gseq [9];
    logic       bseq [9];
    exp_t e;
    gseq = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    bseq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rn_b  = 1'b0;
    req_b = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    rn_b = 1'b1;
    for (int n = 0; n < 9; n++) begin
      exp_q.push_back('{grant: gseq[n], preempt: 1'b0, busy: bseq[n]});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (grant_b !== e.grant) begin failures++; $display("FAIL turn_grant n=%0d got=%b exp=%b", n, grant_b, e.grant); end
      checks++; if (en_n_b !== ~e.grant || oen_b !== (e.grant == 4'b0000)) begin failures++; $display("FAIL turn_enables n=%0d en_n=%b oen=%b", n, en_n_b, oen_b); end
      checks++; if (busy_b !== e.busy || preempt_b !== e.preempt) begin failures++; $display("FAIL turn_busy n=%0d got=%b%b exp=%b%b", n, busy_b, preempt_b, e.busy, e.preempt); end
      if (n == 0) req_b = 4'b0010;
      if (n == 4) req_b = 4'b0000;
    end
    checks++; if (owner_b !== 2'd1) begin failures++; $display("FAIL turn_owner_kept got=%0d exp=1", owner_b); end
    $display("test_turnaround done: owner=%0d busy=%b", owner_b, busy_b);
  endtask

  task automatic test_async_reset;
    exp_t e;
    reset_a(4'b0100);
    exp_q.push_back('{grant: 4'b0100, preempt: 1'b0, busy: 1'b1});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (grant_a !== e.grant) begin failures++; $display("FAIL ar_pre_grant got=%b exp=%b", grant_a, e.grant); end
    @(negedge clk);
    #2 rn_a = 1'b0;
    #1;
    checks++; if (en_n_a !== 4'b1111 || oen_a !== 1'b1) begin failures++; $display("FAIL ar_release en_n=%b oen=%b exp=1111/1", en_n_a, oen_a); end
    checks++; if (grant_a !== 4'b0000 || busy_a !== 1'b0 || preempt_a !== 1'b0) begin failures++; $display("FAIL ar_state grant=%b busy=%b preempt=%b", grant_a, busy_a, preempt_a); end
    checks++; if (owner_a !== 2'd3) begin failures++; $display("FAIL ar_owner got=%0d exp=3", owner_a); end
    req_a = 4'b0101;
    @(negedge clk);
    rn_a = 1'b1;
    exp_q.push_back('{grant: 4'b0001, preempt: 1'b0, busy: 1'b1});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (grant_a !== e.grant || preempt_a !== e.preempt) begin failures++; $display("FAIL ar_first_grant got=%b exp=%b", grant_a, e.grant); end
    $display("test_async_reset done: grant after release=%b", grant_a);
  endtask

  initial begin
    rn_a  = 1'b0;
    rn_b  = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;
    test_reset();
    test_round_robin();
    test_preempt();
    test_solo_owner();
    test_turnaround();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
